// File: rtl/alloc_pkg.sv
// Shared constants, state type and helpers for the physical-register free-list allocator.
// Pointers are 7 bits: a wrap bit above a 6-bit index into the 64-entry free list.
package alloc_pkg;
  localparam int NUM_PR   = 64;
  localparam int NUM_ARCH = 32;
  localparam int WIDTH    = 4;
  localparam int PTR_W    = 7;
  localparam int CNT_W    = 3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } alloc_state_e;

  // A legal retire mask is a run of ones starting at bit 0 (0000, 0001, 0011, ...).
  function automatic logic is_contig(input logic [WIDTH-1:0] v);
    return ((v & (v + WIDTH'(1))) == '0);
  endfunction
endpackage

// File: rtl/alloc_ctrl_if.sv
// Rename-stage <-> allocator bundle. Decode/retire side is the master, the allocator the slave.
// Handshake: a slot with req_valid is granted only when alloc_grant shows it in the same cycle.
interface alloc_ctrl_if;
  import alloc_pkg::*;

  logic [WIDTH-1:0] req_valid;
  logic             stall_in;
  logic [WIDTH-1:0] ret_valid;
  logic             flush;
  logic [PTR_W-1:0] flush_pos;
  logic [WIDTH-1:0] alloc_grant;
  logic [PTR_W-1:0] head_pos;
  logic [PTR_W-1:0] tail_pos;
  logic [WIDTH-1:0] wr_en;
  logic             rename_stall;
  logic             list_empty;
  logic [PTR_W-1:0] free_cnt;
  logic             err;
  alloc_state_e     state;

  modport master (
    output req_valid, stall_in, ret_valid, flush, flush_pos,
    input  alloc_grant, head_pos, tail_pos, wr_en, rename_stall, list_empty, free_cnt, err, state
  );

  modport slave (
    input  req_valid, stall_in, ret_valid, flush, flush_pos,
    output alloc_grant, head_pos, tail_pos, wr_en, rename_stall, list_empty, free_cnt, err, state
  );
endinterface

// File: rtl/alloc_ctrl_popcnt4.sv
// 4-bit population count, purely combinational.
module popcnt4 (
  input  logic [3:0] v,
  output logic [2:0] cnt
);
  assign cnt = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
endmodule

// File: rtl/alloc_ctrl.sv
// Free-list allocator for register renaming: all-or-nothing group grants from head,
// retire returns at tail, single-cycle flush recovery restoring a checkpointed head.
module alloc_ctrl
  import alloc_pkg::PTR_W, alloc_pkg::CNT_W, alloc_pkg::alloc_state_e,
         alloc_pkg::ST_RUN, alloc_pkg::ST_FLUSH, alloc_pkg::is_contig;
#(
  parameter int NUM_PR   = alloc_pkg::NUM_PR,
  parameter int NUM_ARCH = alloc_pkg::NUM_ARCH,
  parameter int WIDTH    = alloc_pkg::WIDTH
) (
  input logic         clk,
  input logic         rst,
  alloc_ctrl_if.slave bus
);
  localparam logic [PTR_W-1:0] MAX_FREE = PTR_W'(NUM_PR - NUM_ARCH);

  logic [WIDTH-1:0] req_v, ret_v;
  logic [CNT_W-1:0] need, ret;
  logic [PTR_W-1:0] head_q, tail_q, free_cnt;
  logic [PTR_W-1:0] head_d, tail_d, free_d;
  alloc_state_e     state_q;
  logic             err_q;
  logic             can_alloc, refuse;

  assign req_v = bus.req_valid;
  assign ret_v = bus.ret_valid;

  popcnt4 u_need (.v(req_v), .cnt(need));
  popcnt4 u_ret  (.v(ret_v), .cnt(ret));

  // Only registered occupancy is used, so same-cycle returns cannot feed allocation.
  assign free_cnt = tail_q - head_q;

  always_comb begin
    can_alloc = 1'b0;
    refuse    = 1'b0;
    if (state_q == ST_FLUSH) begin
      refuse = 1'b1;
    end else if (!bus.stall_in && !bus.flush && need != '0) begin
      if (PTR_W'(need) <= free_cnt) can_alloc = 1'b1;
      else                          refuse    = 1'b1;
    end
  end

  assign head_d = bus.flush ? bus.flush_pos
                            : head_q + (can_alloc ? PTR_W'(need) : '0);
  assign tail_d = tail_q + PTR_W'(ret);
  assign free_d = tail_d - head_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      head_q  <= '0;
      tail_q  <= MAX_FREE;
      err_q   <= 1'b0;
    end else begin
      state_q <= bus.flush ? ST_FLUSH : ST_RUN;
      head_q  <= head_d;
      tail_q  <= tail_d;
      // Sticky: overfilling the list or a gapped retire mask means upstream broke protocol.
      if (free_d > MAX_FREE || !is_contig(ret_v)) err_q <= 1'b1;
    end
  end

  assign bus.alloc_grant  = (can_alloc && !rst) ? req_v : '0;
  assign bus.rename_stall = refuse && !rst;
  assign bus.wr_en        = rst ? '0 : ret_v;
  assign bus.head_pos     = head_q;
  assign bus.tail_pos     = tail_q;
  assign bus.free_cnt     = free_cnt;
  assign bus.list_empty   = (free_cnt == '0);
  assign bus.err          = err_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_alloc_ctrl.sv
// Self-checking bench for alloc_ctrl: directed scenarios plus randomized traffic
// against an integer free-list model.
module tb_alloc_ctrl;
  import alloc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alloc_ctrl_if bus();

  alloc_ctrl #(.NUM_PR(64), .NUM_ARCH(32), .WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  // Reference model: list occupancy as plain integers.
  int m_head, m_tail;
  bit m_in_flush, m_err;

  function automatic int mod128(input int x);
    return ((x % 128) + 128) % 128;
  endfunction

  function automatic int m_free();
    return mod128(m_tail - m_head);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_head = 0; m_tail = 32; m_in_flush = 0; m_err = 0;
  endtask

  task automatic check_regs();
    check("head_pos",   32'(bus.head_pos),   32'(m_head));
    check("tail_pos",   32'(bus.tail_pos),   32'(m_tail));
    check("free_cnt",   32'(bus.free_cnt),   32'(m_free()));
    check("list_empty", 32'(bus.list_empty), 32'(m_free() == 0));
    check("err",        32'(bus.err),        32'(m_err));
    check("state",      32'(bus.state),      32'(m_in_flush));
  endtask

  task automatic drive(input logic [3:0] req, input bit stall, input logic [3:0] ret,
                       input bit fl, input logic [6:0] fpos);
    bus.req_valid = req;
    bus.stall_in  = stall;
    bus.ret_valid = ret;
    bus.flush     = fl;
    bus.flush_pos = fpos;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b1111, 1'b0, 4'b1111, 1'b0, 7'd0);
    #1;
    check("rst_grant", 32'(bus.alloc_grant),  32'd0);
    check("rst_wr_en", 32'(bus.wr_en),        32'd0);
    check("rst_stall", 32'(bus.rename_stall), 32'd0);
    model_reset();
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'b0000, 1'b0, 4'b0000, 1'b0, 7'd0);
  endtask

  // One clock of stimulus: check same-cycle outputs at negedge, state after the edge.
  task automatic step(input logic [3:0] req, input bit stall, input logic [3:0] ret,
                      input bit fl, input logic [6:0] fpos);
    int need, nret, free, nh, nt;
    bit ok, contig;
    drive(req, stall, ret, fl, fpos);
    @(negedge clk);
    need = $countones(req);
    nret = $countones(ret);
    free = m_free();
    ok = !m_in_flush && !stall && !fl && need > 0 && need <= free;
    exp_q.push_back(ok ? 32'(req) : 32'd0);
    exp_q.push_back(32'(m_in_flush || (!stall && !fl && need > free)));
    exp_q.push_back(32'(ret));
    check("alloc_grant",  32'(bus.alloc_grant),  exp_q.pop_front());
    check("rename_stall", 32'(bus.rename_stall), exp_q.pop_front());
    check("wr_en",        32'(bus.wr_en),        exp_q.pop_front());
    contig = (ret == 4'b0000) || (ret == 4'b0001) || (ret == 4'b0011) ||
             (ret == 4'b0111) || (ret == 4'b1111);
    nh = fl ? int'(fpos) : mod128(m_head + (ok ? need : 0));
    nt = mod128(m_tail + nret);
    @(posedge clk);
    #1;
    m_head = nh;
    m_tail = nt;
    m_in_flush = fl;
    if (m_free() > 32 || !contig) m_err = 1;
    check_regs();
  endtask

  initial begin
    int room, rcnt, k;
    logic [3:0] req, ret;
    bit stall, fl;
    logic [6:0] fpos;

    do_reset();

    // Drain the whole list four at a time, then the next group is refused.
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 4'b0000, 1'b0, 7'd0);
    check("drain_head",  32'(bus.head_pos),   32'd32);
    check("drain_empty", 32'(bus.list_empty), 32'd1);
    step(4'b1111, 1'b0, 4'b0000, 1'b0, 7'd0);

    // Partial refill: 3 free refuses a 4-wide group; a same-cycle return only helps next cycle.
    step(4'b0000, 1'b0, 4'b0111, 1'b0, 7'd0);
    step(4'b1111, 1'b0, 4'b0000, 1'b0, 7'd0);
    step(4'b1111, 1'b0, 4'b0001, 1'b0, 7'd0);
    step(4'b1111, 1'b0, 4'b0000, 1'b0, 7'd0);
    check("refill_free", 32'(bus.free_cnt), 32'd0);

    // stall_in and need == 0 both give no grant and no refusal.
    step(4'b0011, 1'b1, 4'b0011, 1'b0, 7'd0);
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 7'd0);

    // Index wrap: head 60 -> 64 -> 68 with the wrap bit toggling.
    do_reset();
    for (int i = 0; i < 15; i++) step(4'b1111, 1'b0, 4'b1111, 1'b0, 7'd0);
    check("wrap_head60", 32'(bus.head_pos), 32'd60);
    check("wrap_tail92", 32'(bus.tail_pos), 32'd92);
    step(4'b1111, 1'b0, 4'b0000, 1'b0, 7'd0);
    check("wrap_idx0",  32'(bus.head_pos[5:0]), 32'd0);
    check("wrap_bit",   32'(bus.head_pos[6]),   32'd1);
    step(4'b1111, 1'b0, 4'b0000, 1'b0, 7'd0);
    check("wrap_head68", 32'(bus.head_pos), 32'd68);

    // Flush with simultaneous returns, one FLUSH cycle, then RUN.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 4'b0000, 1'b0, 7'd0);
    step(4'b1111, 1'b0, 4'b0011, 1'b1, 7'd10);
    check("flush_head",  32'(bus.head_pos), 32'd10);
    check("flush_tail",  32'(bus.tail_pos), 32'd34);
    check("flush_state", 32'(bus.state),    32'd1);
    step(4'b1111, 1'b0, 4'b0000, 1'b0, 7'd0);
    check("flush_run", 32'(bus.state), 32'd0);
    step(4'b0001, 1'b0, 4'b0000, 1'b0, 7'd0);
    // Flush during FLUSH restarts it with the new position.
    step(4'b0000, 1'b0, 4'b0000, 1'b1, 7'd12);
    step(4'b0000, 1'b0, 4'b0000, 1'b1, 7'd11);
    step(4'b0011, 1'b0, 4'b0000, 1'b0, 7'd0);

    // Asynchronous reset in the middle of FLUSH.
    step(4'b0000, 1'b0, 4'b0000, 1'b1, 7'd5);
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", 32'(bus.state),    32'd0);
    check("arst_head",  32'(bus.head_pos), 32'd0);
    check("arst_tail",  32'(bus.tail_pos), 32'd32);
    check("arst_free",  32'(bus.free_cnt), 32'd32);
    do_reset();

    // Error cases: overfilling a full list, and a gapped retire mask.
    step(4'b0000, 1'b0, 4'b0001, 1'b0, 7'd0);
    check("err_overfill", 32'(bus.err), 32'd1);
    step(4'b0000, 1'b0, 4'b0000, 1'b0, 7'd0);
    check("err_sticky", 32'(bus.err), 32'd1);
    do_reset();
    step(4'b0001, 1'b0, 4'b0101, 1'b0, 7'd0);
    check("err_gap", 32'(bus.err), 32'd1);

    // Randomized legal traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req   = 4'($urandom_range(0, 15));
      stall = ($urandom_range(0, 7) == 0);
      room  = 32 - m_free();
      rcnt  = $urandom_range(0, (room < 4) ? room : 4);
      ret   = 4'((1 << rcnt) - 1);
      fl    = ($urandom_range(0, 19) == 0);
      k     = $urandom_range(0, ((room - rcnt) < 8) ? (room - rcnt) : 8);
      fpos  = fl ? 7'(mod128(m_head - k)) : 7'd0;
      step(req, stall, ret, fl, fpos);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alloc_ctrl.md
ALLOC_CTRL -- requirements
Module: alloc_ctrl

Interface
REQ-001 Parameter NUM_PR, default 64, total physical registers.
REQ-002 Parameter NUM_ARCH, default 32, architectural registers permanently mapped, so max free = NUM_PR-NUM_ARCH = 32.
REQ-003 Parameter WIDTH, default 4, rename slots per cycle.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  4  per-slot "needs new PR" from decode.
REQ-007 stall_in  in  1  downstream stall; blocks allocation.
REQ-008 ret_valid  in  4  retiring slots freeing a PR; must be contiguous from bit 0.
REQ-009 flush  in  1  pipeline flush pulse.
REQ-010 flush_pos  in  7  checkpointed head pointer to restore.
REQ-011 alloc_grant  out  4  slots granted a PR this cycle.
REQ-012 head_pos  out  7  free-list read pointer (wrap bit + 6-bit index).
REQ-013 tail_pos  out  7  free-list write pointer.
REQ-014 wr_en  out  4  free-list write enables, slot i writes at tail_pos+i.
REQ-015 rename_stall  out  1  allocation group refused this cycle.
REQ-016 list_empty  out  1  free_cnt == 0.
REQ-017 free_cnt  out  7  tail_pos - head_pos, modulo 128.
REQ-018 err  out  1  sticky protocol error.

Function
REQ-019 States: RUN, FLUSH; encoding 1 bit.
REQ-020 need = popcount(req_valid); ret = popcount(ret_valid); both 3-bit.
REQ-021 In RUN, with !stall_in, !flush and need <= free_cnt: alloc_grant = req_valid in the same cycle (combinational), rename_stall = 0, head_pos += need at the next edge.
REQ-022 All-or-nothing: if need > free_cnt, alloc_grant = 0, rename_stall = 1 and head_pos is unchanged.
REQ-023 stall_in = 1 forces alloc_grant = 0 and rename_stall = 0; head_pos is held.
REQ-024 need = 0 gives alloc_grant = 0 and rename_stall = 0.
REQ-025 wr_en = ret_valid in every state; tail_pos += ret at the next edge.
REQ-026 Returns in a cycle are not usable by allocation in that same cycle; they become visible in free_cnt at the next edge.
REQ-027 Pointer arithmetic is 7-bit modulo 128, and the index wraps at 64.
REQ-028 flush = 1 in any state: alloc_grant = 0 that cycle, head_pos <= flush_pos at the next edge, state <= FLUSH.
REQ-029 FLUSH lasts exactly 1 cycle with grants blocked and rename_stall = 1, then RUN.
REQ-030 A flush during FLUSH restarts FLUSH with the new flush_pos.
REQ-031 Simultaneous flush and returns: both are applied, giving a new head and tail + ret.
REQ-032 err sets and holds until reset if the next free_cnt > NUM_PR-NUM_ARCH, or if ret_valid is non-contiguous (e.g. 4'b0101).
REQ-033 When err is set, wr_en is still driven as ret_valid; no corrective action is taken.

Reset
REQ-034 rst asynchronously forces state = RUN, head_pos = 0, tail_pos = NUM_PR-NUM_ARCH (32), err = 0.
REQ-035 During reset, alloc_grant = 0, wr_en = 0 and rename_stall = 0.
REQ-036 Reset mid-flush or mid-allocation discards all pending updates.

Structure
REQ-037 Shared package alloc_pkg holds NUM_PR, NUM_ARCH, WIDTH, the pointer width 7 and the state enum.
REQ-038 One sub-module, popcnt4 (4-bit population count, combinational), is instantiated twice.
REQ-039 Total RTL is 120-400 lines.

Verification
REQ-040 Reset, then req_valid = 4'b1111 for 8 cycles with no returns -> grants on 8 cycles, head_pos 0->32, free_cnt 32->0, list_empty = 1 after the 8th grant; 9th cycle rename_stall = 1.
REQ-041 free_cnt = 3 with req_valid = 4'b1111 -> alloc_grant = 0, rename_stall = 1; then ret_valid = 4'b0001 -> next cycle grant 4'b1111, free_cnt = 0.
REQ-042 head_pos = 60, tail_pos = 92, 4-wide allocation ×2 -> head_pos 64 then 68; the 6-bit index wraps 60->0->4 and the wrap bit toggles.
REQ-043 flush = 1 with flush_pos = 7'd10 and ret_valid = 4'b0011 at the same time -> head_pos = 10, tail_pos += 2, one FLUSH cycle with rename_stall = 1, then RUN.
REQ-044 free_cnt = 32 with ret_valid = 4'b0001 -> err = 1 and stays 1; ret_valid = 4'b0101 from a fresh reset -> err = 1.
REQ-045 Assert rst mid-FLUSH -> immediately state = RUN, head_pos = 0, tail_pos = 32, free_cnt = 32.
